fetch_unit: RTL and testbench

//   Instruction fetch stage. Owns the PC, issues word reads to instruction memory,
//   and holds each fetched word on ir_out for the decode stage (ir_out drives Decoder.ir).

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 69 ++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, instruction length,
// default reset PC and an alignment helper.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Also the decoder's instruction length; keep the two in step.
    localparam logic [31:0] INSTR_LEN        = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Non-overlapped instruction fetch: one read in flight, one word buffered for decode.
// Redirects from execute take priority; misaligned targets park the stage in FAULT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir_out,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        misaligned
);

    fetch_state_t state;
    logic [31:0]  pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            ir_out <= '0;
            ir_pc  <= '0;
        end else if (state == BOOT) begin
            state <= FETCH;
        end else if (redirect) begin
            // Any in-flight read or buffered word is dropped; memory sees the new address.
            pc    <= redirect_pc;
            state <= is_aligned(redirect_pc) ? FETCH : FAULT;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir_out <= mem_rdata;
                        ir_pc  <= pc;
                        pc     <= pc + INSTR_LEN;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (ir_ready) begin
                        state <= FETCH;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    // Handshake outputs come only from the state register, never from inputs.
    assign mem_req    = (state == FETCH);
    assign ir_valid   = (state == HOLD);
    assign misaligned = (state == FAULT);
    assign mem_addr   = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven fetch vectors with a scoreboard queue,
// plus hand-written redirect, misalignment, wrap and async-reset sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req, mem_ready, redirect, ir_valid, ir_ready, misaligned;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, ir_out, ir_pc;

    logic        mem_req2, mem_ready2, redirect2, ir_valid2, ir_ready2, misaligned2;
    logic [31:0] mem_addr2, mem_rdata2, redirect_pc2, ir_out2, ir_pc2;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .misaligned(misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ready(mem_ready2), .mem_rdata(mem_rdata2),
        .redirect(redirect2), .redirect_pc(redirect_pc2),
        .ir_out(ir_out2), .ir_pc(ir_pc2), .ir_valid(ir_valid2), .ir_ready(ir_ready2),
        .misaligned(misaligned2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic [31:0] data;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    vec_t vecs[4];
    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chk("wait_mem_req", {31'd0, mem_req}, 32'd1);
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got ir_out=%h", name, ir_out);
        end else begin
            e = sbq.pop_front();
            chk({name, "_ir_out"}, ir_out, e.data);
            chk({name, "_ir_pc"}, ir_pc, e.pc);
        end
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0000_0000, lat: 2, data: 32'h0000_0093, hold: 0};
        vecs[1] = '{addr: 32'h0000_0004, lat: 0, data: 32'hDEAD_BEEF, hold: 5};
        vecs[2] = '{addr: 32'h0000_0008, lat: 1, data: 32'h1234_5678, hold: 1};
        vecs[3] = '{addr: 32'h0000_000C, lat: 3, data: 32'hCAFE_F00D, hold: 0};

        rst_n = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0; redirect = 1'b0; redirect_pc = '0; ir_ready = 1'b0;
        mem_ready2 = 1'b0; mem_rdata2 = '0; redirect2 = 1'b0; redirect_pc2 = '0; ir_ready2 = 1'b0;

        // Reset state
        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_ir_out", ir_out, 32'd0);
        chk("rst_ir_pc", ir_pc, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        step();
        rst_n = 1'b1;
        chk("boot_idle", {31'd0, mem_req}, 32'd0);
        step();
        chk("req_after_boot", {31'd0, mem_req}, 32'd1);

        // Table-driven fetches
        for (int i = 0; i < 4; i++) begin
            wait_req();
            chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
            for (int c = 0; c < vecs[i].lat; c++) begin
                step();
                chk($sformatf("v%0d_req_held", i), {31'd0, mem_req}, 32'd1);
                chk($sformatf("v%0d_addr_held", i), mem_addr, vecs[i].addr);
            end
            mem_ready = 1'b1;
            mem_rdata = vecs[i].data;
            sbq.push_back('{data: vecs[i].data, pc: vecs[i].addr});
            step();
            mem_ready = 1'b0;
            mem_rdata = 32'hXXXX_XXXX;
            chk($sformatf("v%0d_ir_valid", i), {31'd0, ir_valid}, 32'd1);
            chk($sformatf("v%0d_req_low", i), {31'd0, mem_req}, 32'd0);
            pop_compare($sformatf("v%0d", i));
            for (int c = 0; c < vecs[i].hold; c++) begin
                step();
                chk($sformatf("v%0d_hold_valid", i), {31'd0, ir_valid}, 32'd1);
                chk($sformatf("v%0d_hold_ir", i), ir_out, vecs[i].data);
                chk($sformatf("v%0d_hold_pc", i), ir_pc, vecs[i].addr);
                chk($sformatf("v%0d_hold_req", i), {31'd0, mem_req}, 32'd0);
            end
            ir_ready = 1'b1;
            step();
            ir_ready = 1'b0;
            chk($sformatf("v%0d_next_req", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("v%0d_next_addr", i), mem_addr, vecs[i].addr + 32'd4);
            chk($sformatf("v%0d_valid_drop", i), {31'd0, ir_valid}, 32'd0);
        end

        // Redirect colliding with mem_ready: data dropped
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        mem_ready = 1'b0; redirect = 1'b0;
        chk("redir_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("redir_req", {31'd0, mem_req}, 32'd1);
        chk("redir_addr", mem_addr, 32'h0000_0100);
        chk("redir_ir_kept", ir_out, 32'hCAFE_F00D);

        // Redirect in HOLD beats ir_ready
        mem_ready = 1'b1; mem_rdata = 32'h0000_0513;
        sbq.push_back('{data: 32'h0000_0513, pc: 32'h0000_0100});
        step();
        mem_ready = 1'b0;
        pop_compare("redir_fetch");
        ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0180;
        step();
        ir_ready = 1'b0; redirect = 1'b0;
        chk("hold_redir_valid", {31'd0, ir_valid}, 32'd0);
        chk("hold_redir_addr", mem_addr, 32'h0000_0180);

        // Misaligned redirect, then recovery
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        chk("mis_valid", {31'd0, ir_valid}, 32'd0);
        mem_ready = 1'b1; ir_ready = 1'b1;
        step(); step();
        mem_ready = 1'b0; ir_ready = 1'b0;
        chk("mis_stuck", {31'd0, misaligned}, 32'd1);
        chk("mis_stuck_req", {31'd0, mem_req}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        chk("mis_clear", {31'd0, misaligned}, 32'd0);
        chk("mis_recover_req", {31'd0, mem_req}, 32'd1);
        chk("mis_recover_addr", mem_addr, 32'h0000_0200);

        // PC wrap on the second instance
        chk("wrap_addr", mem_addr2, 32'hFFFF_FFFC);
        mem_ready2 = 1'b1; mem_rdata2 = 32'h0000_0013;
        step();
        mem_ready2 = 1'b0;
        chk("wrap_valid", {31'd0, ir_valid2}, 32'd1);
        chk("wrap_ir_pc", ir_pc2, 32'hFFFF_FFFC);
        chk("wrap_ir_out", ir_out2, 32'h0000_0013);
        ir_ready2 = 1'b1;
        step();
        ir_ready2 = 1'b0;
        chk("wrap_next_req", {31'd0, mem_req2}, 32'd1);
        chk("wrap_next_addr", mem_addr2, 32'h0000_0000);

        // Asynchronous reset mid-FETCH (dut is fetching 0x200)
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_valid", {31'd0, ir_valid}, 32'd0);
        chk("arst_ir_out", ir_out, 32'd0);
        chk("arst_ir_pc", ir_pc, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_mis", {31'd0, misaligned}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_restart_req", {31'd0, mem_req}, 32'd1);
        chk("arst_restart_addr", mem_addr, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
